// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the datapath bus arbiter.
// Select codes from 24 to 31 make the bus mux drive zero, so SEL_IDLE parks the bus.
package bus_arb_pkg;

   localparam int unsigned NREQ_DEF     = 24;
   localparam int unsigned MAX_HOLD_DEF = 8;
   localparam int unsigned SEL_W        = 5;

   localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(24);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      HANDOFF
   } state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority picker: the first set request at or above ptr wins, wrapping to 0.
// If no request sits at or above ptr, the lowest set bit wins.
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int unsigned N = NREQ_DEF
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             valid,
   output logic [SEL_W-1:0] index
);

   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int unsigned j = 0; j < N; j++) begin
         if (!valid && req[j] && (SEL_W'(j) >= ptr)) begin
            valid = 1'b1;
            index = SEL_W'(j);
         end
      end
      for (int unsigned j = 0; j < N; j++) begin
         if (!valid && req[j]) begin
            valid = 1'b1;
            index = SEL_W'(j);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the shared 32-bit bus with bounded hold time.
// grant, select and busy come from one register stage, so they always agree.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned NREQ     = NREQ_DEF,
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  grant,
   output logic [SEL_W-1:0] select,
   output logic             busy
);

   localparam int unsigned      HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(NREQ - 1);

   state_t            state, state_d;
   logic [SEL_W-1:0]  ptr, ptr_d;
   logic [SEL_W-1:0]  pick_idx, select_d;
   logic [HOLD_W-1:0] hold_cnt, hold_d;
   logic [NREQ-1:0]   grant_d;
   logic              pick_valid, owner_req, others_req, hold_full;

   assign owner_req  = |(req & grant);
   assign others_req = |(req & ~grant);
   assign hold_full  = (hold_cnt == HOLD_LAST);

   rr_pick #(.N(NREQ)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .index (pick_idx)
   );

   // State and output registers
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         grant    <= '0;
         select   <= SEL_IDLE;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         ptr      <= ptr_d;
         hold_cnt <= hold_d;
         grant    <= grant_d;
         select   <= select_d;
         busy     <= (state_d == GRANT);
      end
   end

   // Next state: owner keeps the bus until it lets go or its hold budget runs out
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (pick_valid) state_d = GRANT;
         GRANT: begin
            if (!owner_req)                  state_d = HANDOFF;
            else if (hold_full && others_req) state_d = HANDOFF;
         end
         HANDOFF: state_d = pick_valid ? GRANT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next register values; a new owner is only ever taken from IDLE or HANDOFF
   always_comb begin
      grant_d  = '0;
      select_d = SEL_IDLE;
      ptr_d    = ptr;
      hold_d   = '0;
      if (state_d == GRANT) begin
         if (state == GRANT) begin
            grant_d  = grant;
            select_d = select;
            hold_d   = hold_full ? hold_cnt : hold_cnt + HOLD_W'(1);
         end else begin
            grant_d  = NREQ'(1) << pick_idx;
            select_d = pick_idx;
            ptr_d    = (pick_idx == LAST_IDX) ? '0 : pick_idx + SEL_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of the bus arbiter: reset, release, preemption,
// pointer wrap, solo ownership, back-to-back handoffs and long-run fairness.
module tb_bus_arbiter;
   import bus_arb_pkg::*;

   localparam int unsigned NREQ     = 24;
   localparam int unsigned MAX_HOLD = 8;
   localparam int unsigned WAIT_MAX = NREQ * (MAX_HOLD + 1);

   logic             clock = 1'b0;
   logic             clear;
   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  grant;
   logic [SEL_W-1:0] select;
   logic             busy;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
      .clock  (clock),
      .clear  (clear),
      .req    (req),
      .grant  (grant),
      .select (select),
      .busy   (busy)
   );

   // Expected {grant, select, busy} when the given select code owns the bus
   function automatic logic [NREQ+SEL_W:0] outs_for(input logic [SEL_W-1:0] s);
      if (s == SEL_IDLE) return {{NREQ{1'b0}}, s, 1'b0};
      return {NREQ'(1) << s, s, 1'b1};
   endfunction

   task automatic pulse_clear();
      req   = '0;
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      req   = '0;
      clear = 1'b1;
      #1;
      checks++;
      if ({grant, select, busy} !== outs_for(SEL_IDLE))
         $display("FAIL reset_state: got grant=%h select=%0d busy=%b want idle", grant, select, busy);
      @(negedge clock);
      clear = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         checks++;
         if ({grant, select, busy} !== outs_for(SEL_IDLE)) begin
            errors++;
            $display("FAIL idle_no_req c%0d: got grant=%h select=%0d busy=%b want idle", k, grant, select, busy);
         end
      end
      req = NREQ'(1) << 1;
      @(negedge clock);
      checks++;
      if ({grant, select, busy} !== outs_for(SEL_W'(1))) begin
         errors++;
         $display("FAIL pre_clear_grant: got select=%0d grant=%h want select=1", select, grant);
      end
      clear = 1'b1;
      #1;
      checks++;
      if ({grant, select, busy} !== outs_for(SEL_IDLE)) begin
         errors++;
         $display("FAIL async_clear: got grant=%h select=%0d busy=%b want idle", grant, select, busy);
      end
      @(negedge clock);
      req   = '0;
      clear = 1'b0;
   endtask

   task automatic test_release();
      logic [SEL_W-1:0] exp_sel;
      pulse_clear();
      req = NREQ'(1) << 5;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         exp_sel = (k <= 3) ? SEL_W'(5) : SEL_IDLE;
         checks++;
         if ({grant, select, busy} !== outs_for(exp_sel)) begin
            errors++;
            $display("FAIL release c%0d: got select=%0d grant=%h busy=%b want select=%0d", k, select, grant, busy, exp_sel);
         end
         if (k == 3) req = '0;
      end
   endtask

   task automatic test_preempt();
      logic [SEL_W-1:0] owners [3];
      logic [SEL_W-1:0] exp_sel;
      owners[0] = SEL_W'(2);
      owners[1] = SEL_W'(7);
      owners[2] = SEL_W'(20);
      pulse_clear();
      req = (NREQ'(1) << 2) | (NREQ'(1) << 7) | (NREQ'(1) << 20);
      for (int k = 0; k < 4 * (MAX_HOLD + 1); k++) begin
         @(negedge clock);
         exp_sel = ((k % (MAX_HOLD + 1)) < MAX_HOLD) ? owners[(k / (MAX_HOLD + 1)) % 3] : SEL_IDLE;
         checks++;
         if ({grant, select, busy} !== outs_for(exp_sel)) begin
            errors++;
            $display("FAIL preempt c%0d: got select=%0d grant=%h want select=%0d", k, select, grant, exp_sel);
         end
      end
      req = '0;
   endtask

   task automatic test_wrap();
      logic [SEL_W-1:0] exp_seq [5];
      exp_seq[0] = SEL_W'(22);
      exp_seq[1] = SEL_IDLE;
      exp_seq[2] = SEL_W'(0);
      exp_seq[3] = SEL_IDLE;
      exp_seq[4] = SEL_W'(22);
      pulse_clear();
      req = NREQ'(1) << 22;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         checks++;
         if ({grant, select, busy} !== outs_for(exp_seq[k])) begin
            errors++;
            $display("FAIL wrap_ptr23 s%0d: got select=%0d want %0d", k, select, exp_seq[k]);
         end
         if (k == 0) req = '0;
         if (k == 1) req = (NREQ'(1) << 22) | NREQ'(1);
         if (k == 2) req = NREQ'(1) << 22;
      end
      pulse_clear();
      req = NREQ'(1) << 23;
      @(negedge clock);
      checks++;
      if ({grant, select, busy} !== outs_for(SEL_W'(23))) begin
         errors++;
         $display("FAIL top_source: got select=%0d want 23", select);
      end
      req = '0;
      @(negedge clock);
      req = (NREQ'(1) << 23) | (NREQ'(1) << 1);
      @(negedge clock);
      checks++;
      if ({grant, select, busy} !== outs_for(SEL_W'(1))) begin
         errors++;
         $display("FAIL wrap_after_23: got select=%0d want 1", select);
      end
      req = '0;
   endtask

   task automatic test_solo_then_preempt();
      pulse_clear();
      req = NREQ'(1) << 3;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         checks++;
         if ({grant, select, busy} !== outs_for(SEL_W'(3))) begin
            errors++;
            $display("FAIL solo_hold c%0d: got select=%0d grant=%h want 3", k, select, grant);
         end
      end
      req = (NREQ'(1) << 3) | (NREQ'(1) << 9);
      @(negedge clock);
      checks++;
      if ({grant, select, busy} !== outs_for(SEL_IDLE)) begin
         errors++;
         $display("FAIL solo_preempt: got select=%0d want 24", select);
      end
      @(negedge clock);
      checks++;
      if ({grant, select, busy} !== outs_for(SEL_W'(9))) begin
         errors++;
         $display("FAIL solo_next_owner: got select=%0d want 9", select);
      end
      req = '0;
   endtask

   task automatic test_back_to_back();
      logic [SEL_W-1:0] srcs [4];
      srcs[0] = SEL_W'(4);
      srcs[1] = SEL_W'(10);
      srcs[2] = SEL_W'(15);
      srcs[3] = SEL_W'(1);
      pulse_clear();
      req = NREQ'(1) << srcs[0];
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         checks++;
         if ({grant, select, busy} !== outs_for(srcs[k])) begin
            errors++;
            $display("FAIL b2b_owner s%0d: got select=%0d want %0d", k, select, srcs[k]);
         end
         req = (k < 3) ? (NREQ'(1) << srcs[k+1]) : '0;
         @(negedge clock);
         checks++;
         if ({grant, select, busy} !== outs_for(SEL_IDLE)) begin
            errors++;
            $display("FAIL b2b_gap s%0d: got select=%0d want 24", k, select);
         end
      end
   endtask

   task automatic test_random();
      int               wait_c [NREQ];
      int               worst;
      logic [SEL_W-1:0] exp_sel;
      pulse_clear();
      for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clock);
         exp_sel = SEL_IDLE;
         for (int i = NREQ - 1; i >= 0; i--) if (grant[i]) exp_sel = SEL_W'(i);
         checks++;
         if ({$onehot0(grant), select, busy} !== {1'b1, exp_sel, (grant != '0)}) begin
            errors++;
            $display("FAIL rand_consistency c%0d: grant=%h select=%0d busy=%b", cyc, grant, select, busy);
         end
         worst = 0;
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !grant[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > worst) worst = wait_c[i];
         end
         checks++;
         if (worst > int'(WAIT_MAX)) begin
            errors++;
            $display("FAIL rand_starvation c%0d: wait=%0d limit=%0d", cyc, worst, WAIT_MAX);
         end
         for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
               if ($urandom_range(3) == 0) req[i] = 1'b0;
            end else if (!req[i]) begin
               if ($urandom_range(7) == 0) req[i] = 1'b1;
            end
         end
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_release();
      test_preempt();
      test_wrap();
      test_solo_then_preempt();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
